// File: rtl/shift_sequencer.sv
// Multishift controller: clocks the datapath a microinstruction-supplied number of
// times while holding the microsequencer, with memory-wait stalls honoured throughout.
module shift_sequencer #(
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shiftREQ,
  input  logic [CNT_WIDTH-1:0] shiftCNT,
  input  logic                 busWAIT,
  output logic                 clkenDP,
  output logic                 clkenCR,
  output logic                 shiftBUSY,
  output logic                 shiftDONE,
  output logic [CNT_WIDTH-1:0] shiftREM
);

  // state   | meaning
  // S_IDLE  | normal single-step; a request with n>=2 performs the first shift here
  // S_SHIFT | sequencer held, datapath clocked until the remaining count reaches 1
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    clkenDP = 1'b0;
    clkenCR = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!busWAIT) begin
          if (!shiftREQ) begin
            clkenDP = 1'b1;
            clkenCR = 1'b1;
          end else if (shiftCNT == '0) begin
            clkenCR = 1'b1;
          end else if (shiftCNT == CNT_ONE) begin
            clkenDP = 1'b1;
            clkenCR = 1'b1;
          end else begin
            clkenDP = 1'b1;
            cnt_d   = shiftCNT - CNT_ONE;
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (!busWAIT) begin
          clkenDP = 1'b1;
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            // last shift: release the sequencer on the same cycle
            clkenCR = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // enables must drop the instant reset asserts, not at the next edge
    if (rst) begin
      clkenDP = 1'b0;
      clkenCR = 1'b0;
    end
  end

  assign shiftBUSY = (state_q == S_SHIFT);
  assign shiftDONE = done_q;
  assign shiftREM  = cnt_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: fixed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based model of planned shifts.
module tb_shift_sequencer;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         shiftREQ;
  logic [W-1:0] shiftCNT;
  logic         busWAIT;
  logic         clkenDP, clkenCR, shiftBUSY, shiftDONE;
  logic [W-1:0] shiftREM;

  shift_sequencer #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .shiftREQ(shiftREQ), .shiftCNT(shiftCNT),
    .busWAIT(busWAIT), .clkenDP(clkenDP), .clkenCR(clkenCR),
    .shiftBUSY(shiftBUSY), .shiftDONE(shiftDONE), .shiftREM(shiftREM)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int acc_dp = 0, acc_cr = 0, acc_done = 0;

  // model: one entry per shift still owed after the accept cycle; entry=1 marks the last
  bit pend[$];
  bit m_done = 1'b0;

  typedef struct {
    logic         req;
    logic [W-1:0] cnt;
    logic         w;
    logic         dp, cr, busy, done;
    logic [W-1:0] rem;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic dp, input logic cr,
                       input logic busy, input logic done, input logic [W-1:0] rem);
    n_vec++;
    if ({clkenDP, clkenCR, shiftBUSY, shiftDONE} !== {dp, cr, busy, done} || shiftREM !== rem) begin
      n_bad++;
      $display("FAIL %s t=%0t: got dp=%b cr=%b busy=%b done=%b rem=%0d, want dp=%b cr=%b busy=%b done=%b rem=%0d",
               name, $time, clkenDP, clkenCR, shiftBUSY, shiftDONE, shiftREM, dp, cr, busy, done, rem);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic model_check(input string name);
    logic dp, cr;
    if (rst) begin
      dp = 1'b0; cr = 1'b0;
    end else if (busWAIT) begin
      dp = 1'b0; cr = 1'b0;
    end else if (pend.size() > 0) begin
      dp = 1'b1; cr = pend[0];
    end else if (!shiftREQ) begin
      dp = 1'b1; cr = 1'b1;
    end else if (shiftCNT == 0) begin
      dp = 1'b0; cr = 1'b1;
    end else if (shiftCNT == 1) begin
      dp = 1'b1; cr = 1'b1;
    end else begin
      dp = 1'b1; cr = 1'b0;
    end
    acc_dp   += int'(clkenDP);
    acc_cr   += int'(clkenCR);
    acc_done += int'(shiftDONE);
    check(name, dp, cr, pend.size() > 0, m_done, W'(pend.size()));
  endtask

  task automatic model_edge();
    int n;
    if (rst) begin
      pend.delete();
      m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (busWAIT) return;
    if (pend.size() > 0) begin
      m_done = pend.pop_front();
    end else if (shiftREQ && shiftCNT >= 2) begin
      n = int'(shiftCNT);
      for (int i = 0; i < n - 2; i++) pend.push_back(1'b0);
      pend.push_back(1'b1);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic [W-1:0] cnt, input logic w);
    shiftREQ = req;
    shiftCNT = cnt;
    busWAIT  = w;
    #4;
  endtask

  task automatic step(input logic req, input logic [W-1:0] cnt, input logic w, input string name);
    drive(req, cnt, w);
    model_check(name);
    advance();
  endtask

  initial begin
    bit finished;
    //            req   cnt     w     dp    cr    busy  done  rem
    tbl[0]  = '{1'b1, 10'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[1]  = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd3};
    tbl[2]  = '{1'b1, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd2};
    tbl[3]  = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1};
    tbl[4]  = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[5]  = '{1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[6]  = '{1'b1, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};
    tbl[7]  = '{1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[8]  = '{1'b1, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[9]  = '{1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd2};
    tbl[10] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd2};
    tbl[11] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd1};
    tbl[12] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[13] = '{1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[14] = '{1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0};

    rst = 1'b1; shiftREQ = 1'b0; shiftCNT = '0; busWAIT = 1'b0;
    @(negedge clk);
    #1 check("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    advance();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].req, tbl[i].cnt, tbl[i].w);
      check($sformatf("tbl%0d", i), tbl[i].dp, tbl[i].cr, tbl[i].busy, tbl[i].done, tbl[i].rem);
      advance();
    end

    // reset in the middle of a 5-shift sequence
    step(1'b1, 10'd5, 1'b0, "rm_accept");
    step(1'b0, 10'd0, 1'b0, "rm_shift1");
    shiftREQ = 1'b0; busWAIT = 1'b0;
    rst = 1'b1;
    #1;
    pend.delete(); m_done = 1'b0;
    check("rst_mid_immediate", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    advance();
    #1 check("rst_mid_hold", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    drive(1'b0, 10'd0, 1'b0);
    check("rst_release", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    advance();

    // maximum count
    acc_dp = 0; acc_cr = 0; acc_done = 0;
    step(1'b1, 10'd1023, 1'b0, "max_accept");
    finished = 1'b0;
    for (int j = 0; j < 1100; j++) begin
      drive(1'b0, 10'd0, 1'b0);
      if (!shiftBUSY) begin
        finished = 1'b1;
        break;
      end
      model_check("max_shift");
      advance();
    end
    check_int("max_terminates", int'(finished), 1);
    check_int("max_dp_pulses", acc_dp, 1023);
    check_int("max_cr_pulses", acc_cr, 1);
    model_check("max_done");
    advance();

    // back-to-back 2 then 3
    acc_dp = 0; acc_done = 0;
    step(1'b1, 10'd2, 1'b0, "b2b_a_accept");
    step(1'b1, 10'd3, 1'b0, "b2b_a_last");
    step(1'b1, 10'd3, 1'b0, "b2b_b_accept");
    step(1'b0, 10'd0, 1'b0, "b2b_b_shift");
    step(1'b0, 10'd0, 1'b0, "b2b_b_last");
    check_int("b2b_dp_contiguous", acc_dp, 5);
    check_int("b2b_first_done", acc_done, 1);
    step(1'b0, 10'd0, 1'b0, "b2b_end");
    check_int("b2b_done_total", acc_done, 2);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      logic         r_req, r_w;
      logic [W-1:0] r_cnt;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #1;
        pend.delete(); m_done = 1'b0;
        check("rand_rst", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        advance();
        rst = 1'b0;
      end
      r_req = ($urandom_range(0, 2) == 0);
      r_w   = ($urandom_range(0, 4) == 0);
      r_cnt = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 5));
      step(r_req, r_cnt, r_w, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Counter-based multishift controller that generates the datapath and microsequencer clock enables.
- Replaces FE-sign-driven fast shifting: the microinstruction supplies an explicit shift count, and the block holds the microsequencer while it clocks the datapath exactly that many times.
- Sits between the control ROM field decode, the memory wait logic, and the DP/CR clock-enable nets.

Parameters:
- CNT_WIDTH, 10, width of the shift count and of the internal down-counter (matches FE width).

Ports:
- clk  input  1  clock; all registers sample on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- shiftREQ  input  1  current microinstruction requests a multishift.
- shiftCNT  input  CNT_WIDTH  unsigned number of shifts n, sampled only on the request cycle in IDLE.
- busWAIT  input  1  memory wait; stalls everything.
- clkenDP  output  1  datapath clock enable (combinational).
- clkenCR  output  1  microsequencer clock enable (combinational).
- shiftBUSY  output  1  registered; high while in SHIFT.
- shiftDONE  output  1  registered one-cycle pulse after the final shift of an n>=2 sequence.
- shiftREM  output  CNT_WIDTH  registered remaining-counter value, for debug.

Behaviour:
- States: IDLE, SHIFT. The counter is CNT_WIDTH bits.
- Reset (asynchronous):
  - state=IDLE, counter=0, shiftBUSY=0, shiftDONE=0, shiftREM=0.
  - clkenDP=clkenCR=0 while rst is high.
- IDLE, busWAIT=1:
  - clkenDP=clkenCR=0; no state or counter change; shiftREQ ignored.
- IDLE, busWAIT=0, shiftREQ=0:
  - clkenDP=clkenCR=1 (normal single-step).
- IDLE, busWAIT=0, shiftREQ=1:
  - n=0: clkenDP=0, clkenCR=1. Datapath untouched, sequencer advances, stay IDLE, no shiftDONE.
  - n=1: clkenDP=clkenCR=1, stay IDLE, no shiftDONE.
  - n>=2: clkenDP=1 (first shift), clkenCR=0, counter<=n-1, next state SHIFT.
- SHIFT, busWAIT=1:
  - clkenDP=clkenCR=0; counter holds; stay in SHIFT.
- SHIFT, busWAIT=0:
  - clkenDP=1 always.
  - counter>1: clkenCR=0, counter<=counter-1.
  - counter==1: clkenCR=1, counter<=0, next state IDLE, shiftDONE=1 on the following cycle.
- shiftREQ and shiftCNT are ignored in SHIFT; the CROM is frozen because clkenCR=0.
- Totals for a sequence with no waits:
  - Exactly n clkenDP pulses, n>=2.
  - clkenCR low for n-1 cycles, then one high cycle coincident with the last DP pulse.
  - Total duration is n cycles; a busWAIT-high cycle adds one cycle and no pulse.
- shiftBUSY=1 exactly in the cycles where state==SHIFT. shiftREM mirrors the counter.
- Maximum n = 2^CNT_WIDTH-1 (1023); there is no wrap, and the counter never decrements below 0.
- A request can be accepted in the cycle immediately after returning to IDLE, giving back-to-back sequences with no idle gap.
- rst asserted mid-sequence: immediate return to IDLE, enables forced 0, no shiftDONE pulse.
- clkenCR=1 implies busWAIT=0 in all states.

Test Plan:
- Reset mid-sequence: shiftREQ=1, shiftCNT=5; assert rst after 2 cycles -> clkenDP=clkenCR=0 immediately; shiftBUSY=0; shiftREM=0; no shiftDONE; after release, shiftREQ=0 gives clkenDP=clkenCR=1.
- Basic sequence: shiftREQ=1, shiftCNT=4, busWAIT=0:
  - clkenDP high 4 consecutive cycles; clkenCR pattern 0,0,0,1.
  - shiftREM 3,2,1 during SHIFT; shiftDONE pulses once at cycle 5.
- Edge counts:
  - shiftCNT=0 -> one cycle with clkenDP=0, clkenCR=1, no BUSY.
  - shiftCNT=1 -> one cycle with both enables 1, no BUSY, no DONE.
- Wait insertion: shiftCNT=3, busWAIT=1 in the 2nd cycle only -> enables 0 that cycle; shiftREM holds at 2; total 4 cycles; still exactly 3 DP pulses.
- Maximum count: shiftCNT=1023 -> 1023 DP pulses, clkenCR high only on the last; shiftREM never wraps.
- Back-to-back: shiftCNT=2 then shiftCNT=3 immediately after -> DP pulses 2+3 contiguous; two shiftDONE pulses; IDLE→SHIFT re-entry with no gap.
